// File: rtl/raster_tri_scheduler_pkg.sv
// Shared types for the triangle front-end scheduler.
//   vertex_t         : one screen-space vertex
//   triangle_setup_t : result of triangle_setup, valid=0 marks a degenerate triangle
//   tri_packet_t     : three vertices as stored in the input queue
//   setup_state_t / rast_state_t : scheduler FSM encodings
package raster_tri_scheduler_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic        [15:0] z;
    } vertex_t;

    typedef struct packed {
        logic               valid;
        logic signed [31:0] area;
        logic        [15:0] min_x;
        logic        [15:0] min_y;
        logic        [15:0] max_x;
        logic        [15:0] max_y;
    } triangle_setup_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } tri_packet_t;

    typedef enum logic {S_IDLE, S_WAIT} setup_state_t;
    typedef enum logic {R_IDLE, R_BUSY} rast_state_t;

endpackage

// File: rtl/raster_tri_scheduler_if.sv
// Handshake bundle between the scheduler, the vertex source and the external
// triangle_setup / rasterizer units.
//   master : the scheduler (accepts triangles, drives the start pulses)
//   slave  : the surrounding environment
interface raster_tri_scheduler_if;
    import raster_tri_scheduler_pkg::*;

    vertex_t         v0, v1, v2;
    logic            tri_valid;
    logic            tri_ready;
    vertex_t         setup_v0, setup_v1, setup_v2;
    logic            setup_start;
    triangle_setup_t setup_result;
    logic            setup_done;
    triangle_setup_t rast_tri;
    logic            rast_start;
    logic            rast_done;

    modport master (
        input  v0, v1, v2, tri_valid,
        output tri_ready,
        output setup_v0, setup_v1, setup_v2, setup_start,
        input  setup_result, setup_done,
        output rast_tri, rast_start,
        input  rast_done
    );

    modport slave (
        output v0, v1, v2, tri_valid,
        input  tri_ready,
        input  setup_v0, setup_v1, setup_v2, setup_start,
        output setup_result, setup_done,
        input  rast_tri, rast_start,
        output rast_done
    );
endinterface

// File: rtl/raster_tri_scheduler_sync_fifo.sv
// celery_sync_fifo: single-clock show-ahead FIFO, element type and depth
// parametrised, synchronous active-high reset.
//   wr_en/wr_data : push (ignored when full)
//   rd_en/rd_data : pop; rd_data always shows the head entry
//   full/empty/count : occupancy
module celery_sync_fifo #(
    parameter type T        = logic [7:0],
    parameter int  DEPTH    = 4,
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  T                 wr_data,
    input  logic             rd_en,
    output T                 rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/raster_tri_scheduler.sv
// Multi-triangle front-end scheduler. Queues incoming triangles, overlaps setup
// of the next triangle with rasterization of the current one through a small
// setup-result buffer, drops degenerate triangles, preserves arrival order.
//   clk, rst     : clock, synchronous active-high reset
//   bus (master) : vertex input handshake, setup and rasterizer start/done
//   busy         : anything queued, buffered, in flight or about to start
//   tri_count    : triangles issued to the rasterizer (saturating)
//   degen_count  : triangles dropped as degenerate (saturating)
// Build option: define RAST_SCHED_STATS_EN to enable the statistics counters;
// otherwise both counter outputs are tied to 0.
//
// state  | meaning
// S_IDLE | setup unit free, may issue when queue has data and buffer has room
// S_WAIT | one triangle in triangle_setup, waiting for setup_done
// R_IDLE | rasterizer free, issues when setup buffer has data
// R_BUSY | rasterizer working on rast_tri, waiting for rast_done
module raster_tri_scheduler
    import raster_tri_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH     = 4,
    parameter int SETUP_BUF_DEPTH = 2,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    raster_tri_scheduler_if.master bus,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] tri_count,
    output logic [STAT_WIDTH-1:0] degen_count
);

    localparam int Q_CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int SB_CW = $clog2(SETUP_BUF_DEPTH + 1);

    setup_state_t    s_state, s_next;
    rast_state_t     r_state, r_next;

    tri_packet_t     q_wr, q_rd;
    logic            q_push, q_pop, q_full, q_empty;
    logic [Q_CW-1:0] q_count;

    triangle_setup_t  sb_rd;
    logic             sb_push, sb_pop, sb_full, sb_empty;
    logic [SB_CW-1:0] sb_count;

    logic setup_start_r;
    logic rast_start_r;

    assign q_wr          = '{v0: bus.v0, v1: bus.v1, v2: bus.v2};
    assign q_push        = bus.tri_valid && !q_full;
    assign bus.tri_ready = !q_full;

    celery_sync_fifo #(.T(tri_packet_t), .DEPTH(QUEUE_DEPTH)) u_tri_queue (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (q_push),
        .wr_data (q_wr),
        .rd_en   (q_pop),
        .rd_data (q_rd),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    celery_sync_fifo #(.T(triangle_setup_t), .DEPTH(SETUP_BUF_DEPTH)) u_setup_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sb_push),
        .wr_data (bus.setup_result),
        .rd_en   (sb_pop),
        .rd_data (sb_rd),
        .full    (sb_full),
        .empty   (sb_empty),
        .count   (sb_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s_state <= S_IDLE;
            r_state <= R_IDLE;
        end else begin
            s_state <= s_next;
            r_state <= r_next;
        end
    end

    // Only one setup can be in flight and it lives in S_WAIT, so in S_IDLE the
    // "buffered + in flight < depth" reservation reduces to a non-full buffer.
    always_comb begin
        s_next  = s_state;
        q_pop   = 1'b0;
        sb_push = 1'b0;
        case (s_state)
            S_IDLE: begin
                if (!q_empty && !sb_full) begin
                    q_pop  = 1'b1;
                    s_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.setup_done) begin
                    sb_push = bus.setup_result.valid;
                    s_next  = S_IDLE;
                end
            end
            default: s_next = S_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        sb_pop = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!sb_empty) begin
                    sb_pop = 1'b1;
                    r_next = R_BUSY;
                end
            end
            R_BUSY: begin
                if (bus.rast_done) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            setup_start_r <= 1'b0;
            rast_start_r  <= 1'b0;
            bus.setup_v0  <= '0;
            bus.setup_v1  <= '0;
            bus.setup_v2  <= '0;
            bus.rast_tri  <= '0;
        end else begin
            setup_start_r <= q_pop;
            rast_start_r  <= sb_pop;
            if (q_pop) begin
                bus.setup_v0 <= q_rd.v0;
                bus.setup_v1 <= q_rd.v1;
                bus.setup_v2 <= q_rd.v2;
            end
            if (sb_pop) begin
                bus.rast_tri <= sb_rd;
            end
        end
    end

    assign bus.setup_start = setup_start_r;
    assign bus.rast_start  = rast_start_r;

    assign busy = (q_count != '0) || (s_state == S_WAIT) || (sb_count != '0) ||
                  (r_state == R_BUSY) || setup_start_r || rast_start_r;

`ifdef RAST_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_count   <= '0;
            degen_count <= '0;
        end else begin
            if (sb_pop && (tri_count != '1)) begin
                tri_count <= tri_count + STAT_WIDTH'(1);
            end
            if ((s_state == S_WAIT) && bus.setup_done && !bus.setup_result.valid &&
                (degen_count != '1)) begin
                degen_count <= degen_count + STAT_WIDTH'(1);
            end
        end
    end
`else
    assign tri_count   = '0;
    assign degen_count = '0;
`endif

endmodule

// File: tb/tb_raster_tri_scheduler.sv
// Directed bench for raster_tri_scheduler: single-triangle latency, queue
// back-pressure and ordering, setup-buffer reservation with a stalled
// rasterizer, reset mid-operation, and degenerate-triangle dropping.
// Counter expectations follow whether RAST_SCHED_STATS_EN is defined.
module tb_raster_tri_scheduler;
    import raster_tri_scheduler_pkg::*;

`ifdef RAST_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [31:0] tri_count;
    logic [31:0] degen_count;

    raster_tri_scheduler_if bus ();

    raster_tri_scheduler #(
        .QUEUE_DEPTH     (4),
        .SETUP_BUF_DEPTH (2),
        .STAT_WIDTH      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .busy        (busy),
        .tri_count   (tri_count),
        .degen_count (degen_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit              setup_auto = 1'b0;
    bit              rast_auto  = 1'b0;
    int              degen_tag  = -1;
    int              setup_starts = 0;
    triangle_setup_t rast_seen[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic vertex_t mk_vtx(input int a);
        vertex_t v;
        v.x = 16'(a);
        v.y = 16'(a + 1);
        v.z = 16'(a + 2);
        return v;
    endfunction

    function automatic triangle_setup_t mk_res(input int tag, input bit ok);
        triangle_setup_t r;
        r.valid = ok;
        r.area  = 32'(tag * 100);
        r.min_x = 16'(tag);
        r.min_y = 16'(tag + 1);
        r.max_x = 16'(tag + 2);
        r.max_y = 16'(tag + 3);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tri(input int tag);
        bus.v0 = mk_vtx(tag);
        bus.v1 = mk_vtx(tag + 10);
        bus.v2 = mk_vtx(tag + 20);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tri_valid  = 1'b0;
        bus.setup_done = 1'b0;
        bus.rast_done  = 1'b0;
        step();
        step();
        rst = 1'b0;
        setup_starts = 0;
        rast_seen.delete();
    endtask

    task automatic push_seq(input int first, input int last, input string tag);
        for (int t = first; t <= last; t++) begin
            int  c  = 0;
            bit  ok = 1'b0;
            set_tri(t);
            bus.tri_valid = 1'b1;
            while (!ok && c < 40) begin
                @(negedge clk);
                ok = bus.tri_ready;
                c++;
                step();
            end
            if (!ok) chk({tag, "_push_timeout"}, 128'(1), 128'(0));
        end
        bus.tri_valid = 1'b0;
    endtask

    task automatic wait_done(input int n_rast, input int budget, input string tag);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(rast_seen.size() >= n_rast && !busy) && c < budget);
        chk({tag, "_timeout"}, 128'(c >= budget), 128'(0));
    endtask

    // monitor
    initial forever begin
        @(negedge clk);
        if (bus.setup_start) setup_starts++;
        if (bus.rast_start)  rast_seen.push_back(bus.rast_tri);
    end

    // setup unit model: answers one cycle after setup_start
    initial forever begin
        @(negedge clk);
        if (setup_auto && bus.setup_start) begin
            int tag;
            tag = int'(bus.setup_v0.x);
            step();
            bus.setup_result = mk_res(tag, tag != degen_tag);
            bus.setup_done   = 1'b1;
            step();
            bus.setup_done   = 1'b0;
        end
    end

    // rasterizer model: finishes two cycles after rast_start
    initial forever begin
        @(negedge clk);
        if (rast_auto && bus.rast_start) begin
            step();
            step();
            bus.rast_done = 1'b1;
            step();
            bus.rast_done = 1'b0;
        end
    end

    initial begin
        int acc;
        int c;

        bus.v0 = '0; bus.v1 = '0; bus.v2 = '0;
        bus.tri_valid    = 1'b0;
        bus.setup_result = '0;
        bus.setup_done   = 1'b0;
        bus.rast_done    = 1'b0;

        // ---- 1: reset state and single-triangle latency
        do_reset();
        @(negedge clk);
        chk("rst_busy",        128'(busy),             128'(0));
        chk("rst_tri_ready",   128'(bus.tri_ready),    128'(1));
        chk("rst_setup_start", 128'(bus.setup_start),  128'(0));
        chk("rst_rast_start",  128'(bus.rast_start),   128'(0));
        chk("rst_rast_tri",    128'(bus.rast_tri),     128'(0));
        chk("rst_setup_v0",    128'(bus.setup_v0),     128'(0));
        chk("rst_tri_count",   128'(tri_count),        128'(0));
        chk("rst_degen_count", 128'(degen_count),      128'(0));

        step();
        set_tri(1);
        bus.tri_valid = 1'b1;
        @(negedge clk);
        chk("t1_start_t0", 128'(bus.setup_start), 128'(0));
        step();
        bus.tri_valid = 1'b0;
        @(negedge clk);
        chk("t1_start_t1", 128'(bus.setup_start), 128'(0));
        chk("t1_busy_t1",  128'(busy),            128'(1));
        step();
        @(negedge clk);
        chk("t1_start_t2", 128'(bus.setup_start), 128'(1));
        chk("t1_setup_v0", 128'(bus.setup_v0),    128'(mk_vtx(1)));
        chk("t1_setup_v2", 128'(bus.setup_v2),    128'(mk_vtx(21)));
        step();
        @(negedge clk);
        chk("t1_start_t3", 128'(bus.setup_start), 128'(0));
        repeat (4) step();
        bus.setup_result = mk_res(1, 1'b1);
        bus.setup_done   = 1'b1;
        @(negedge clk);
        chk("t1_rast_d0", 128'(bus.rast_start), 128'(0));
        step();
        bus.setup_done = 1'b0;
        @(negedge clk);
        chk("t1_rast_d1", 128'(bus.rast_start), 128'(0));
        step();
        @(negedge clk);
        chk("t1_rast_d2",   128'(bus.rast_start), 128'(1));
        chk("t1_rast_tri",  128'(bus.rast_tri),   128'(mk_res(1, 1'b1)));
        step();
        @(negedge clk);
        chk("t1_rast_d3",   128'(bus.rast_start), 128'(0));
        chk("t1_busy_rast", 128'(busy),           128'(1));
        bus.rast_done = 1'b1;
        step();
        bus.rast_done = 1'b0;
        @(negedge clk);
        chk("t1_busy_end",   128'(busy),         128'(0));
        chk("t1_tri_count",  128'(tri_count),    128'(STATS ? 1 : 0));
        chk("t1_setups",     128'(setup_starts), 128'(1));

        // ---- 2: back-pressure and ordering. Triangle 1 leaves the queue into
        // setup (held in S_WAIT), so five are accepted before the queue is full.
        do_reset();
        acc = 0;
        c   = 0;
        set_tri(1);
        bus.tri_valid = 1'b1;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (!bus.tri_ready) break;
            acc++;
            step();
            set_tri(acc + 1);
        end
        chk("t2_acc_at_full", 128'(acc), 128'(5));
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("t2_hold_not_ready", 128'(bus.tri_ready), 128'(0));
        end
        step();
        setup_auto = 1'b1;
        rast_auto  = 1'b1;
        bus.setup_result = mk_res(1, 1'b1);
        bus.setup_done   = 1'b1;
        step();
        bus.setup_done   = 1'b0;
        push_seq(6, 6, "t2");
        wait_done(6, 300, "t2_drain");
        chk("t2_rast_n", 128'(rast_seen.size()), 128'(6));
        for (int i = 0; i < 6 && i < rast_seen.size(); i++) begin
            chk($sformatf("t2_order_%0d", i), 128'(rast_seen[i]), 128'(mk_res(i + 1, 1'b1)));
        end
        chk("t2_tri_count", 128'(tri_count), 128'(STATS ? 6 : 0));

        // ---- 3: stalled rasterizer, instant setup
        step();
        do_reset();
        setup_auto = 1'b1;
        rast_auto  = 1'b0;
        push_seq(11, 17, "t3");
        repeat (20) step();
        @(negedge clk);
        chk("t3_setups",    128'(setup_starts),      128'(3));
        chk("t3_rast_n",    128'(rast_seen.size()),  128'(1));
        chk("t3_tri_ready", 128'(bus.tri_ready),     128'(0));
        chk("t3_busy",      128'(busy),              128'(1));
        chk("t3_tri_count", 128'(tri_count),         128'(STATS ? 1 : 0));
        step();
        bus.rast_done = 1'b1;
        step();
        bus.rast_done = 1'b0;
        repeat (15) step();
        @(negedge clk);
        chk("t3_setups_after", 128'(setup_starts),     128'(4));
        chk("t3_rast_n_after", 128'(rast_seen.size()), 128'(2));
        if (rast_seen.size() >= 2)
            chk("t3_second_tri", 128'(rast_seen[1]), 128'(mk_res(12, 1'b1)));
        chk("t3_tri_ready_after", 128'(bus.tri_ready), 128'(1));

        // ---- 5: reset while R_BUSY with three queued, then stray dones
        setup_auto = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy",        128'(busy),            128'(0));
        chk("t5_tri_ready",   128'(bus.tri_ready),   128'(1));
        chk("t5_tri_count",   128'(tri_count),       128'(0));
        chk("t5_degen_count", 128'(degen_count),     128'(0));
        chk("t5_rast_tri",    128'(bus.rast_tri),    128'(0));
        step();
        bus.rast_done    = 1'b1;
        bus.setup_result = mk_res(99, 1'b0);
        bus.setup_done   = 1'b1;
        step();
        bus.rast_done  = 1'b0;
        bus.setup_done = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("t5_stray_busy",   128'(busy),             128'(0));
        chk("t5_stray_setups", 128'(setup_starts),     128'(4));
        chk("t5_stray_rast_n", 128'(rast_seen.size()), 128'(2));
        chk("t5_stray_degen",  128'(degen_count),      128'(0));

        // ---- 4 / 6: degenerate triangle dropped
        step();
        do_reset();
        setup_auto = 1'b1;
        rast_auto  = 1'b1;
        degen_tag  = 22;
        push_seq(21, 23, "t4");
        wait_done(2, 200, "t4_drain");
        chk("t4_rast_n", 128'(rast_seen.size()), 128'(2));
        if (rast_seen.size() >= 2) begin
            chk("t4_first",  128'(rast_seen[0]), 128'(mk_res(21, 1'b1)));
            chk("t4_second", 128'(rast_seen[1]), 128'(mk_res(23, 1'b1)));
        end
        chk("t4_setups",      128'(setup_starts), 128'(3));
        chk("t4_degen_count", 128'(degen_count),  128'(STATS ? 1 : 0));
        chk("t4_tri_count",   128'(tri_count),    128'(STATS ? 2 : 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
